// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the sequential floating-point add/subtract unit.
package fp_addsub_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned in a wide vector.
    function automatic logic [127:0] qnan_bits(input int exp_w, input int man_w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r = r | (128'(1) << (man_w + i));
        end
        r = r | (128'(1) << (man_w - 1));
        return r;
    endfunction

    // Positive infinity {0, all-ones, zeros}; the caller supplies the sign bit.
    function automatic logic [127:0] inf_bits(input int exp_w, input int man_w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) begin
            r = r | (128'(1) << (man_w + i));
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Magnitude compare and saturating right shift of the smaller significand.
module fp_align_shift
    import fp_addsub_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic             a_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] b_man,
    output logic             big_sign,
    output logic [EXP_W-1:0] big_exp,
    output logic [MAN_W:0]   big_sig,
    output logic [MAN_W:0]   small_sig
);

    localparam int unsigned SAT = MAN_W + 2;

    logic [MAN_W:0]   a_sig;
    logic [MAN_W:0]   b_sig;
    logic [MAN_W:0]   small_raw;
    logic [EXP_W-1:0] small_exp;
    logic [EXP_W-1:0] diff;
    logic             b_larger;

    // Flush denormals, pick the larger operand, align the smaller one (truncating).
    always_comb begin
        a_sig     = (a_exp == '0) ? '0 : {1'b1, a_man};
        b_sig     = (b_exp == '0) ? '0 : {1'b1, b_man};
        b_larger  = {b_exp, b_sig} > {a_exp, a_sig};
        big_sign  = b_larger ? b_sign : a_sign;
        big_exp   = b_larger ? b_exp  : a_exp;
        big_sig   = b_larger ? b_sig  : a_sig;
        small_raw = b_larger ? a_sig  : b_sig;
        small_exp = b_larger ? a_exp  : b_exp;
        diff      = big_exp - small_exp;
        if (32'(diff) >= SAT) begin
            small_sig = '0;
        end else begin
            small_sig = small_raw >> diff;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with iterative one-bit normalisation.
module fp_addsub_seq
    import fp_addsub_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 add_sub_signal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic                 exception
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 2;
    localparam logic [127:0] NAN_FULL = qnan_bits(EXP_W, MAN_W);
    localparam logic [127:0] INF_FULL = inf_bits(EXP_W, MAN_W);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             bsgn_q, bsgn_d, sign_q, sign_d, sub_q, sub_d, exc_q, exc_d;
    logic [EXP_W-1:0] exp_q, exp_d, exp_inc;
    logic [MAN_W:0]   big_q, big_d, small_q, small_d;
    logic [SW-1:0]    sum_q, sum_d;

    logic             al_sign;
    logic [EXP_W-1:0] al_exp;
    logic [MAN_W:0]   al_big, al_small;

    fp_align_shift #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_align (
        .a_sign   (a_q[W-1]),
        .a_exp    (a_q[W-2:MAN_W]),
        .a_man    (a_q[MAN_W-1:0]),
        .b_sign   (bsgn_q),
        .b_exp    (b_q[W-2:MAN_W]),
        .b_man    (b_q[MAN_W-1:0]),
        .big_sign (al_sign),
        .big_exp  (al_exp),
        .big_sig  (al_big),
        .small_sig(al_small)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign exception = exc_q;

    // Next-state and datapath: capture, align, add, normalise, hold result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bsgn_d  = bsgn_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        big_d   = big_q;
        small_d = small_q;
        sum_d   = sum_q;
        res_d   = res_q;
        exc_d   = exc_q;
        exp_inc = exp_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    bsgn_d  = b[W-1] ^ add_sub_signal;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (a_q[W-2:MAN_W] == '1 || b_q[W-2:MAN_W] == '1) begin
                    res_d   = NAN_FULL[W-1:0];
                    exc_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    sign_d  = al_sign;
                    exp_d   = al_exp;
                    big_d   = al_big;
                    small_d = al_small;
                    sub_d   = a_q[W-1] ^ bsgn_q;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                : ({1'b0, big_q} + {1'b0, small_q});
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[SW-1]) begin
                    state_d = DONE;
                    if (exp_inc == '1) begin
                        res_d = {sign_q, INF_FULL[W-2:0]};
                        exc_d = 1'b1;
                    end else begin
                        res_d = {sign_q, exp_inc, sum_q[MAN_W:1]};
                        exc_d = 1'b0;
                    end
                end else if (sum_q == '0) begin
                    res_d   = '0;
                    exc_d   = 1'b0;
                    state_d = DONE;
                end else if (sum_q[MAN_W]) begin
                    res_d   = {sign_q, exp_q, sum_q[MAN_W-1:0]};
                    exc_d   = 1'b0;
                    state_d = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    res_d   = {sign_q, {(W-1){1'b0}}};
                    exc_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bsgn_q  <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            big_q   <= '0;
            small_q <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bsgn_q  <= bsgn_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            big_q   <= big_d;
            small_q <= small_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed self-checking bench for fp_addsub_seq (single precision).
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        add_sub_signal = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic        exception;

    int n_checks = 0;
    int n_fail   = 0;

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a             (a),
        .b             (b),
        .add_sub_signal(add_sub_signal),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res           (res),
        .exception     (exception)
    );

    always #5 clk = ~clk;

    // Drives one operation with out_ready=1 and returns result and latency.
    // Latency counts rising edges from the accept edge (accept edge = 1) to
    // the edge after which out_valid is first seen high.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic top,
                         output logic [31:0] r, output logic e, output int lat);
        @(negedge clk);
        a = ta; b = tb_; add_sub_signal = top; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = res;
        e = exception;
        if (out_valid) @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got=%h exp=00000000", res); end
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got=%b exp=0", exception); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] r; logic e; int lat;
        do_op(32'h3F800000, 32'h3F800000, 1'b0, r, e, lat);
        n_checks++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL add_res got=%h exp=40000000", r); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL add_exc got=%b exp=0", e); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_sub_norm();
        logic [31:0] r; logic e; int lat;
        do_op(32'h3F800000, 32'h3FC00000, 1'b1, r, e, lat);
        n_checks++; if (r !== 32'hBF000000) begin n_fail++; $display("FAIL sub_res got=%h exp=BF000000", r); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL sub_exc got=%b exp=0", e); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub_latency got=%0d exp=5", lat); end
    endtask

    task automatic test_cancel_overflow();
        logic [31:0] r; logic e; int lat;
        do_op(32'h3F800000, 32'h3F800000, 1'b1, r, e, lat);
        n_checks++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL cancel_res got=%h exp=00000000", r); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL cancel_exc got=%b exp=0", e); end
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, e, lat);
        n_checks++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL ovf_res got=%h exp=7F800000", r); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL ovf_exc got=%b exp=1", e); end
        // Differing exponents: 2.0 + 0.5 = 2.5 exercises the alignment shift
        do_op(32'h40000000, 32'h3F000000, 1'b0, r, e, lat);
        n_checks++; if (r !== 32'h40200000) begin n_fail++; $display("FAIL align_res got=%h exp=40200000", r); end
    endtask

    task automatic test_nan();
        logic [31:0] r; logic e; int lat;
        do_op(32'h7FC00000, 32'h3F800000, 1'b0, r, e, lat);
        n_checks++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL nan_res got=%h exp=7FC00000", r); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL nan_exc got=%b exp=1", e); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL nan_latency got=%0d exp=2", lat); end
        do_op(32'h7F800000, 32'h7F800000, 1'b1, r, e, lat);
        n_checks++; if (r !== 32'h7FC00000) begin n_fail++; $display("FAIL infinf_res got=%h exp=7FC00000", r); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL infinf_exc got=%b exp=1", e); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; add_sub_signal = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 60) begin @(posedge clk); n++; @(negedge clk); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got=%b exp=1", out_valid); end
        // Present a conflicting operation while the result is stalled
        a = 32'h40400000; b = 32'h40400000; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            n_checks++; if (res !== 32'h40000000) begin n_fail++; $display("FAIL bp_hold_res cyc=%0d got=%h exp=40000000", i, res); end
            n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL bp_hold_exc cyc=%0d got=%b exp=0", i, exception); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_op cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3FC00000; add_sub_signal = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);              // accept -> ALIGN
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);              // -> ADD
        @(posedge clk);              // -> NORM
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL midrst_res got=%h exp=00000000", res); end
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL midrst_exc got=%b exp=0", exception); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_norm();
        test_cancel_overflow();
        test_nan();
        test_backpressure();
        test_reset_mid_op();
        test_add();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised, multi-cycle floating-point add/subtract unit; successor to the combinational single-precision add/sub stub.
- Operands are fields {sign, EXP_W exponent, MAN_W mantissa}. Accepted via valid/ready, result returned via valid/ready.
- Normalisation is iterative, one bit per cycle, so latency depends on the data.
- Sits between the operand register file and the FP writeback arbiter.

Parameters:
- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa width; hidden bit is implied.
- W (localparam), 1+EXP_W+MAN_W: operand/result width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept (high only in IDLE)
- a  input  W  operand A
- b  input  W  operand B
- add_sub_signal  input  1  0 = a+b, 1 = a-b (flips b sign)
- out_valid  output  1  res/exception valid
- out_ready  input  1  consumer accepts result
- res  output  W  result
- exception  output  1  NaN/Inf input or overflow

Behaviour:
- Reset (sync, active-high): state=IDLE; in_ready=1, out_valid=0, res=0, exception=0. Reset mid-operation aborts the operation and discards it; no output is produced.
- States: IDLE -> ALIGN -> ADD -> NORM (stays 1..MAN_W+2 cycles) -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b and effective b sign (b[W-1]^add_sub_signal), then go to ALIGN. Inputs are ignored in all other states.
- ALIGN:
  - Special case: either exponent all-ones -> res = canonical qNaN {0, all-ones, 1, zeros}, exception=1, go to DONE.
  - Denormals: exponent 0 means the operand is flushed to zero.
  - Order operands by magnitude (exponent, then mantissa). Shift the smaller {1,man} right by the exponent difference, saturating at MAN_W+2. Shifted-out bits are truncated; there is no sticky bit.
  - Result sign = sign of the larger-magnitude operand.
- ADD: same effective signs -> add magnitudes; otherwise subtract smaller from larger. Sum is MAN_W+2 bits wide (carry bit included).
- NORM, one decision per cycle:
  - Carry set -> shift right 1, exp+1, go to DONE.
  - Sum == 0 -> result +0, go to DONE.
  - Hidden bit set -> go to DONE.
  - Otherwise shift left 1, exp-1, stay in NORM.
  - Exp reaching 0 -> result signed zero (flush), exception=0, go to DONE.
- Overflow: exponent after NORM equals all-ones -> res = ±Inf (sign kept, mantissa 0), exception=1.
- Rounding: truncation (round toward zero).
- res and exception are registered on entry to DONE.
- DONE: out_valid=1; res and exception held stable until out_ready. On out_valid&&out_ready go to IDLE (in_ready=1 the next cycle). No acceptance in the same cycle, so throughput is at most 1 op per 5 cycles.
- Latency: out_valid rises on the 4th rising edge after the accept edge when NORM takes 1 cycle. Each extra left shift adds 1 cycle. The special-case path takes 2 edges.
- Exact cancellation (x - x) gives +0, exception=0.

Decomposition:
- Package fp_addsub_pkg holds:
  - state enum (IDLE, ALIGN, ADD, NORM, DONE);
  - default EXP_W/MAN_W;
  - canonical-NaN and Inf constant functions parametrised by EXP_W/MAN_W.
- One sub-module, fp_align_shift: combinational magnitude compare plus saturating right shift, used by ALIGN.
- The FSM, adder and normaliser stay in the top module.

Test Plan:
- 0x3F800000 + 0x3F800000 (op=0), out_ready=1 -> res=0x40000000, exception=0; out_valid on the 4th edge after accept.
- 0x3F800000 - 0x3FC00000 (1.0-1.5) -> res=0xBF000000 (-0.5); NORM takes 2 cycles, so latency is 5.
- 0x3F800000 - 0x3F800000 -> res=0x00000000, exception=0. Separately, 0x7F7FFFFF + 0x7F7FFFFF -> res=0x7F800000, exception=1.
- 0x7FC00000 + 0x3F800000 -> res=0x7FC00000, exception=1, out_valid after 2 edges. Also 0x7F800000 - 0x7F800000 -> same NaN.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> res/exception stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next cycle.
- Assert reset in the cycle the unit is in NORM -> next cycle state is IDLE, out_valid=0, res=0, in_ready=1, and no stale result appears later.
